// File: rtl/hdmi_trace_decoder_if.sv
// hdmi_trace_decoder_if: pixel-stream bundle feeding the trace decoder.
// The source drives it through master; the decoder samples it through slave.
interface hdmi_trace_decoder_if;
    logic        pixCe;
    logic        VDEn;
    logic        hSync;
    logic        vSync;
    logic [23:0] pixel;

    modport master (output pixCe, VDEn, hSync, vSync, pixel);
    modport slave  (input  pixCe, VDEn, hSync, vSync, pixel);
endinterface

// File: rtl/hdmi_trace_decoder.sv
// hdmi_trace_decoder: rebuilds the raster position, keeps the topmost lit
// row of every column and replays one trace entry per column after a frame.
module hdmi_trace_decoder #(
    parameter int         WIDTH    = 640,
    parameter int         HEIGHT   = 480,
    parameter logic [7:0] GREEN_TH = 8'h80
) (
    input  logic                 clk,
    input  logic                 rstn,
    hdmi_trace_decoder_if.slave  vid,
    input  logic                 clrErr,
    output logic                 colValid,
    output logic [9:0]           colIdx,
    output logic [9:0]           rowIdx,
    output logic                 colHit,
    output logic                 frameDone,
    output logic                 locked,
    output logic [9:0]           lineCnt,
    output logic [2:0]           timingErr
);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int XW = AW + 1;
    localparam int YW = 11;
    localparam logic [AW-1:0] LAST = AW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_WAIT,
        S_ACTIVE,
        S_DUMP
    } state_t;

    state_t state;
    state_t state_nx;

    logic          vde_q;
    logic          vs_q;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [YW-1:0] y_next;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] dump_k;
    logic          dump_ph;

    logic          a_v;
    logic [AW-1:0] a_x;
    logic [9:0]    a_y;
    logic          b_v;
    logic [AW-1:0] b_x;
    logic [9:0]    b_y;

    logic [10:0]   mem [WIDTH];
    logic [10:0]   rd_q;
    logic [AW-1:0] rd_addr;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [10:0]   mem_wd;

    logic smp_vde;
    logic vs_rise;
    logic vde_fall;
    logic in_active;
    logic cap;
    logic abort;
    logic [2:0] new_err;

    assign smp_vde   = vid.pixCe & vid.VDEn;
    assign vs_rise   = vid.pixCe & vid.vSync & ~vs_q;
    assign vde_fall  = vid.pixCe & ~vid.VDEn & vde_q;
    assign in_active = (state == S_ACTIVE);

    assign y_next = (vde_fall && y_cnt != '1) ? y_cnt + YW'(1) : y_cnt;

    // A pixel sampled with the frame-ending vSync belongs to no frame.
    assign cap = in_active & smp_vde & ~vs_rise
               & (vid.pixel[15:8] >= GREEN_TH)
               & (x_cnt < XW'(WIDTH))
               & (y_cnt < YW'(HEIGHT));

    assign new_err = {
        abort,
        in_active & vs_rise & (y_next != YW'(HEIGHT)),
        in_active & vde_fall & (x_cnt != XW'(WIDTH))
    };

    assign rd_addr = a_v ? a_x : dump_k;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        abort    = 1'b0;
        mem_we   = 1'b0;
        mem_wa   = '0;
        mem_wd   = '0;
        unique case (state)
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_addr;
                if (clr_addr == LAST) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vs_rise) begin
                    state_nx = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    state_nx = S_DUMP;
                end
            end
            S_DUMP: begin
                if (smp_vde) begin
                    abort    = 1'b1;
                    state_nx = S_CLEAR;
                end else if (dump_ph && dump_k == LAST) begin
                    state_nx = S_ACTIVE;
                end
                if (dump_ph) begin
                    mem_we = 1'b1;
                    mem_wa = dump_k;
                end
            end
            default: state_nx = S_CLEAR;
        endcase
        // Only the first lit row of a column is kept.
        if (b_v && !rd_q[10]) begin
            mem_we = 1'b1;
            mem_wa = b_x;
            mem_wd = {1'b1, b_y};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vde_q     <= 1'b0;
            vs_q      <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            clr_addr  <= '0;
            dump_k    <= '0;
            dump_ph   <= 1'b0;
            a_v       <= 1'b0;
            a_x       <= '0;
            a_y       <= '0;
            b_v       <= 1'b0;
            b_x       <= '0;
            b_y       <= '0;
            colValid  <= 1'b0;
            colIdx    <= '0;
            rowIdx    <= '0;
            colHit    <= 1'b0;
            frameDone <= 1'b0;
            locked    <= 1'b0;
            lineCnt   <= '0;
            timingErr <= '0;
        end else begin
            if (vid.pixCe) begin
                vde_q <= vid.VDEn;
                vs_q  <= vid.vSync;
            end

            clr_addr <= (state == S_CLEAR) ? clr_addr + AW'(1) : '0;

            if (state == S_DUMP && !abort) begin
                dump_ph <= ~dump_ph;
                if (dump_ph) begin
                    dump_k <= dump_k + AW'(1);
                end
            end else begin
                dump_ph <= 1'b0;
                dump_k  <= '0;
            end

            if ((state == S_WAIT || in_active) && vs_rise) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (in_active && vid.pixCe) begin
                if (vde_fall) begin
                    x_cnt <= '0;
                    y_cnt <= y_next;
                end else if (vid.VDEn && x_cnt != '1) begin
                    x_cnt <= x_cnt + XW'(1);
                end
            end

            a_v <= cap;
            if (cap) begin
                a_x <= AW'(x_cnt);
                a_y <= y_cnt[9:0];
            end
            b_v <= a_v;
            b_x <= a_x;
            b_y <= a_y;

            if (state == S_CLEAR) begin
                locked <= 1'b0;
            end else if (state == S_WAIT && vs_rise) begin
                locked <= 1'b1;
            end

            if (in_active && vs_rise) begin
                lineCnt <= y_next[9:0];
            end

            timingErr <= (timingErr & {3{~clrErr}}) | new_err;

            colValid  <= 1'b0;
            frameDone <= 1'b0;
            if (state == S_DUMP && dump_ph && !abort) begin
                colValid  <= 1'b1;
                colIdx    <= 10'(dump_k);
                colHit    <= rd_q[10];
                rowIdx    <= rd_q[10] ? rd_q[9:0] : 10'd0;
                frameDone <= (dump_k == LAST);
            end
        end
    end
endmodule

// File: tb/tb_hdmi_trace_decoder.sv
// tb_hdmi_trace_decoder: random frames checked against a scan-based model of
// the topmost lit row per column, plus geometry, abort and reset scenarios.
module tb_hdmi_trace_decoder;
    localparam int W  = 32;
    localparam int H  = 24;
    localparam int TH = 128;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clrErr;
    logic       colValid;
    logic [9:0] colIdx;
    logic [9:0] rowIdx;
    logic       colHit;
    logic       frameDone;
    logic       locked;
    logic [9:0] lineCnt;
    logic [2:0] timingErr;

    hdmi_trace_decoder_if vid ();

    hdmi_trace_decoder #(
        .WIDTH(W),
        .HEIGHT(H),
        .GREEN_TH(8'(TH))
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .vid(vid),
        .clrErr(clrErr),
        .colValid(colValid),
        .colIdx(colIdx),
        .rowIdx(rowIdx),
        .colHit(colHit),
        .frameDone(frameDone),
        .locked(locked),
        .lineCnt(lineCnt),
        .timingErr(timingErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int idx;
        int row;
        int hit;
        int fd;
    } ev_t;

    ev_t ev_q[$];

    always @(negedge clk) begin
        if (colValid) begin
            ev_q.push_back('{cyc, int'(colIdx), int'(rowIdx),
                             int'(colHit), int'(frameDone)});
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    logic [7:0] gimg [H][W];
    int len [H];
    int nl;
    int exp_hit [W];
    int exp_row [W];
    int last_pc;
    int t_vs;
    int ab_cyc;
    int any_fd;
    int any_late;

    task automatic ref_trace();
        for (int c = 0; c < W; c++) begin
            exp_hit[c] = 0;
            exp_row[c] = 0;
            for (int r = 0; r < nl; r++) begin
                if (exp_hit[c] == 0 && c < len[r] && gimg[r][c] >= 8'(TH)) begin
                    exp_hit[c] = 1;
                    exp_row[c] = r;
                end
            end
        end
    endtask

    function automatic logic [7:0] dim();
        return 8'($urandom_range(0, TH - 1));
    endfunction

    // mode 0: nothing lit, 1: row 10 lit, 2: (5,2) and (5,20), 3: sparse random
    task automatic img_fill(input int mode);
        int pick;
        for (int r = 0; r < H; r++) begin
            len[r] = W;
            for (int c = 0; c < W; c++) begin
                gimg[r][c] = dim();
                case (mode)
                    1: if (r == 10) gimg[r][c] = 8'($urandom_range(TH, 255));
                    2: if (c == 5 && (r == 2 || r == 20)) gimg[r][c] = 8'hff;
                    3: begin
                        pick = $urandom_range(0, 39);
                        if (pick == 0) gimg[r][c] = 8'($urandom_range(TH, 255));
                        else if (pick == 1) gimg[r][c] = 8'(TH);
                        else if (pick == 2) gimg[r][c] = 8'(TH - 1);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic pix(input logic vde, input logic hs, input logic vs,
                       input logic [7:0] g, input logic clr);
        @(posedge clk);
        #1;
        last_pc     = cyc;
        vid.pixCe   = 1'b1;
        vid.VDEn    = vde;
        vid.hSync   = hs;
        vid.vSync   = vs;
        vid.pixel   = {8'($urandom), g, 8'($urandom)};
        clrErr      = clr;
        @(posedge clk);
        #1;
        vid.pixCe   = 1'b0;
        clrErr      = 1'b0;
    endtask

    task automatic send_lines(input bit tight, input bit clr_fall);
        for (int r = 0; r < nl; r++) begin
            for (int c = 0; c < len[r]; c++) begin
                pix(1'b1, 1'b0, 1'b0, gimg[r][c], 1'b0);
            end
            if (!(tight && r == nl - 1)) begin
                for (int b = 0; b < 4; b++) begin
                    pix(1'b0, (b == 1 || b == 2), 1'b0, 8'h00,
                        (b == 0) && clr_fall && (len[r] != W));
                end
            end
        end
    endtask

    task automatic vsync_blank(input int nblank);
        pix(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        t_vs = last_pc;
        pix(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < nblank; i++) begin
            pix(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic check_replay(input int t);
        chk("ncol", ev_q.size(), W);
        for (int i = 0; i < ev_q.size() && i < W; i++) begin
            chk($sformatf("idx%0d", i), ev_q[i].idx, i);
            chk($sformatf("hit%0d", i), ev_q[i].hit, exp_hit[i]);
            chk($sformatf("row%0d", i), ev_q[i].row, exp_row[i]);
            chk($sformatf("cyc%0d", i), ev_q[i].cyc, t + 3 + 2 * i);
            chk($sformatf("fd%0d", i), ev_q[i].fd, (i == W - 1) ? 1 : 0);
        end
        ev_q.delete();
    endtask

    task automatic frame(input int mode, input bit tight, input int short_r,
                         input bit clr_fall, input int lines, input bit do_chk);
        img_fill(mode);
        nl = lines;
        if (short_r >= 0) len[short_r] = W - 1;
        ref_trace();
        send_lines(tight, clr_fall);
        vsync_blank(40);
        if (do_chk) check_replay(t_vs);
    endtask

    task automatic clr_pulse();
        @(posedge clk);
        #1 clrErr = 1'b1;
        @(posedge clk);
        #1 clrErr = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_valid"}, colValid, 0);
        chk({pfx, "_idx"}, colIdx, 0);
        chk({pfx, "_row"}, rowIdx, 0);
        chk({pfx, "_hit"}, colHit, 0);
        chk({pfx, "_fd"}, frameDone, 0);
        chk({pfx, "_lock"}, locked, 0);
        chk({pfx, "_lcnt"}, lineCnt, 0);
        chk({pfx, "_err"}, timingErr, 0);
    endtask

    initial begin
        rstn      = 1'b0;
        clrErr    = 1'b0;
        vid.pixCe = 1'b0;
        vid.VDEn  = 1'b0;
        vid.hSync = 1'b0;
        vid.vSync = 1'b0;
        vid.pixel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (W + 8) @(posedge clk);
        @(negedge clk);
        chk("wait_lock", locked, 0);

        vsync_blank(40);
        chk("lock", locked, 1);
        chk("lock_noev", ev_q.size(), 0);
        ev_q.delete();

        frame(1, 1'b0, -1, 1'b0, H, 1'b1);
        chk("hl_lcnt", lineCnt, H);
        chk("hl_err", timingErr, 0);

        frame(2, 1'b0, -1, 1'b0, H, 1'b1);
        frame(0, 1'b0, -1, 1'b0, H, 1'b1);

        frame(3, 1'b0, 7, 1'b1, H, 1'b1);
        chk("short_err", timingErr, 1);
        chk("short_lcnt", lineCnt, H);
        clr_pulse();
        chk("short_clr", timingErr, 0);

        frame(3, 1'b0, -1, 1'b0, H - 1, 1'b1);
        chk("nl_err", timingErr, 2);
        chk("nl_lcnt", lineCnt, H - 1);
        clr_pulse();

        frame(3, 1'b1, -1, 1'b0, H, 1'b1);
        chk("tight_err", timingErr, 0);
        chk("tight_lcnt", lineCnt, H);

        for (int f = 0; f < 3; f++) begin
            frame(3, 1'($urandom_range(0, 1)), -1, 1'b0, H, 1'b1);
        end
        chk("rnd_err", timingErr, 0);

        // VDEn during replay at column 10
        img_fill(3);
        nl = H;
        send_lines(1'b0, 1'b0);
        vsync_blank(0);
        for (int i = 0; i < 40; i++) begin
            if (ev_q.size() >= 11) break;
            pix(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        chk("abort_reach", (ev_q.size() >= 11) ? 1 : 0, 1);
        pix(1'b1, 1'b0, 1'b0, 8'hff, 1'b0);
        ab_cyc = last_pc;
        repeat (7) pix(1'b1, 1'b0, 1'b0, 8'hff, 1'b0);
        repeat (44) pix(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        any_fd   = 0;
        any_late = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i].fd != 0) any_fd = 1;
            if (ev_q[i].cyc > ab_cyc) any_late = 1;
        end
        chk("abort_fd", any_fd, 0);
        chk("abort_late", any_late, 0);
        chk("abort_err", timingErr, 4);
        chk("abort_lock", locked, 0);
        ev_q.delete();
        clr_pulse();
        vsync_blank(40);
        chk("resume_early", ev_q.size(), 0);
        chk("resume_lock", locked, 1);
        frame(3, 1'b0, -1, 1'b0, H, 1'b1);

        // reset in the middle of a replay
        img_fill(1);
        nl = H;
        send_lines(1'b0, 1'b0);
        vsync_blank(10);
        @(posedge clk);
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("mid");
        @(posedge clk);
        #1 rstn = 1'b1;
        ev_q.delete();
        repeat (5) pix(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        vsync_blank(30);
        chk("clr_lock", locked, 0);
        frame(3, 1'b0, -1, 1'b0, H, 1'b0);
        chk("clr_vs_noev", ev_q.size(), 0);
        chk("clr_relock", locked, 1);
        ev_q.delete();
        frame(0, 1'b0, -1, 1'b0, H, 1'b1);
        chk("end_err", timingErr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
